// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter: op codes, op field layout,
// FSM state encoding and the fixed error result values.
package calc_pkg;

  typedef struct packed {
    logic       ms;
    logic [2:0] op;
  } calc_opcode_t;

  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0001;
  localparam logic [3:0] OP_MUL      = 4'b0010;
  localparam logic [3:0] OP_DIV      = 4'b0011;
  localparam logic [3:0] OP_SQR      = 4'b1100;
  localparam logic [3:0] OP_CUBE     = 4'b1101;
  localparam logic [3:0] OP_FACT     = 4'b1110;
  localparam logic [3:0] OP_PASS_ADD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } calc_arb_state_t;

  localparam logic [6:0] CALC_DIV0_RESULT    = 7'h7F;
  localparam logic [6:0] CALC_ILLEGAL_RESULT = 7'h00;
  localparam logic [6:0] CALC_TIMEOUT_RESULT = 7'h00;

  function automatic logic calc_op_legal(input calc_opcode_t o);
    return o inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                     OP_SQR, OP_CUBE, OP_FACT, OP_PASS_ADD};
  endfunction

  function automatic logic calc_op_div0(input calc_opcode_t o, input logic [2:0] b);
    return (o == OP_DIV) && (b == 3'b000);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward;
// on advance the pointer moves to one past the current grant.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);
  localparam int unsigned PW = $clog2(N_REQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  int unsigned   pos;

  // Priority level i is position (ptr + i) mod N_REQ; first valid level wins.
  always_comb begin
    grant = '0;
    pos   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (grant == '0 && req[j] && pos == j) grant[j] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (grant[j]) ptr_nxt = PW'((j + 1) % N_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        ptr <= '0;
    else if (advance) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one multi-cycle calculator engine among N_REQ requesters with
// per-requester result memory. Optional WAIT watchdog: CALC_ARB_TIMEOUT_EN.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*4-1:0] req_op,
  input  logic [N_REQ*3-1:0] req_a,
  input  logic [N_REQ*3-1:0] req_b,
  input  logic [N_REQ-1:0]   req_chain,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [6:0]         rsp_result,
  output logic               rsp_err,
  output logic               eng_start,
  output logic [3:0]         eng_op,
  output logic [6:0]         eng_a,
  output logic [2:0]         eng_b,
  input  logic               eng_done,
  input  logic [6:0]         eng_result
);
  localparam int unsigned IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("calc_arbiter: parameter out of range");
  end

  calc_arb_state_t state, state_nxt;
  logic [N_REQ-1:0] grant;
  logic             accept;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cur;
  calc_opcode_t     sel_op, cap_op;
  logic [6:0]       sel_a, cap_a, res_q;
  logic [2:0]       sel_b, cap_b;
  logic             sel_bad, sel_div0, err_q, timed_out;
  logic [6:0]       mem [N_REQ];

  // Pointer advances at accept rather than in RESP: no grant can occur in
  // between, and reset clears it either way, so the order seen is identical.
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    grant_idx = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IW'(i);
        sel_op    = req_op[i*4 +: 4];
        sel_a     = req_chain[i] ? mem[i] : {4'b0000, req_a[i*3 +: 3]};
        sel_b     = req_b[i*3 +: 3];
      end
    end
    sel_bad  = !calc_op_legal(sel_op);
    sel_div0 = calc_op_div0(sel_op, sel_b);
  end

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + CW'(1);
  end

  assign timed_out = (state == WAIT) && !eng_done && (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = '0;
    eng_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (!reset && grant != '0) begin
          accept    = 1'b1;
          req_ready = grant;
          state_nxt = (sel_bad || sel_div0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done || timed_out) state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = (state == RESP) && (cur == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= '0;
      cap_op <= '0;
      cap_a  <= '0;
      cap_b  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        cur    <= grant_idx;
        cap_op <= sel_op;
        cap_a  <= sel_a;
        cap_b  <= sel_b;
        if (sel_bad) begin
          res_q <= CALC_ILLEGAL_RESULT;
          err_q <= 1'b1;
        end else if (sel_div0) begin
          res_q <= CALC_DIV0_RESULT;
          err_q <= 1'b1;
        end
      end
      if (state == WAIT) begin
        if (eng_done) begin
          res_q <= eng_result;
          err_q <= 1'b0;
        end else if (timed_out) begin
          res_q <= CALC_TIMEOUT_RESULT;
          err_q <= 1'b1;
        end
      end
      if (state == RESP && !err_q) mem[cur] <= res_q;
    end
  end

  assign eng_op     = cap_op;
  assign eng_a      = cap_a;
  assign eng_b      = cap_b;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Randomized self-checking bench for calc_arbiter; the bench plays the
// engine and predicts grants, operands and responses from a queue-free model.
module tb_calc_arbiter;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, req_chain, rsp_valid;
  logic [N*4-1:0] req_op;
  logic [N*3-1:0] req_a, req_b;
  logic [6:0]     rsp_result, eng_a, eng_result;
  logic           rsp_err, eng_start, eng_done;
  logic [3:0]     eng_op;
  logic [2:0]     eng_b;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_ptr;
  logic [6:0] m_mem [N];

  always #5 clk = ~clk;

  calc_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_chain  (req_chain),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_op     (eng_op),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [6:0] eng_model(input logic [3:0] op, input logic [6:0] a, input logic [2:0] b);
    int r;
    int av = int'(a);
    int bv = int'(b);
    case (op)
      4'b0000: r = av + bv;
      4'b0001: r = av - bv;
      4'b0010: r = av * bv;
      4'b0011: r = av / bv;
      4'b1100: r = av * av;
      4'b1101: r = av * av * av;
      4'b1110: begin r = 1; for (int i = 2; i <= av; i++) r = r * i; end
      default: r = av + bv;
    endcase
    return 7'(r);
  endfunction

  task automatic set_cmd(input int i, input logic [3:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic ch);
    req_op[i*4 +: 4] = op;
    req_a[i*3 +: 3]  = a;
    req_b[i*3 +: 3]  = b;
    req_chain[i]     = ch;
  endtask

  task automatic rand_cmds();
    for (int i = 0; i < N; i++)
      set_cmd(i, 4'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
  endtask

  // Starts just after a negedge with the DUT idle; ends the same way.
  task automatic run_round(input logic [N-1:0] v, input int k);
    int         g;
    logic [3:0] op;
    logic [2:0] a, b;
    logic [6:0] aeff, r;
    req_valid = v;
    #1;
    g = pick(v, m_ptr);
    check("ready_grant", req_ready, (g < 0) ? 0 : (1 << g));
    if (g < 0) begin
      @(negedge clk);
      return;
    end
    op    = req_op[g*4 +: 4];
    a     = req_a[g*3 +: 3];
    b     = req_b[g*3 +: 3];
    aeff  = req_chain[g] ? m_mem[g] : {4'b0000, a};
    m_ptr = (g + 1) % N;
    @(negedge clk);
    #1;
    check("ready_busy", req_ready, 0);
    if (op[3] != op[2] || (op == 4'b0011 && b == 3'd0)) begin
      check("err_rsp_valid", rsp_valid, 1 << g);
      check("err_result", rsp_result, (op[3] != op[2]) ? 7'h00 : 7'h7F);
      check("err_flag", rsp_err, 1);
      check("err_no_start", eng_start, 0);
    end else begin
      check("issue_start", eng_start, 1);
      check("issue_rsp_quiet", rsp_valid, 0);
      check("issue_eng_bus", {eng_op, eng_a, eng_b}, {op, aeff, b});
      r = eng_model(op, aeff, b);
      for (int j = 1; j < k; j++) begin
        @(negedge clk);
        #1;
        check("wait_quiet", {eng_start, rsp_valid, req_ready}, 0);
        check("wait_eng_hold", {eng_op, eng_a, eng_b}, {op, aeff, b});
      end
      @(negedge clk);
      eng_done   = 1'b1;
      eng_result = r;
      #1;
      check("done_quiet", rsp_valid, 0);
      check("done_eng_hold", {eng_op, eng_a, eng_b}, {op, aeff, b});
      @(negedge clk);
      eng_done   = 1'b0;
      eng_result = 7'($urandom);
      #1;
      check("rsp_valid", rsp_valid, 1 << g);
      check("rsp_result", rsp_result, r);
      check("rsp_err", rsp_err, 0);
      check("rsp_ready_busy", req_ready, 0);
      m_mem[g] = r;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] v;
    int           c;
    reset      = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    req_chain  = '0;
    eng_done   = 1'b0;
    eng_result = '0;
    m_ptr      = 0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;

    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_result, rsp_err}, 0);
    check("rst_eng", {eng_start, eng_op, eng_a, eng_b}, 0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    // ADD 3+4 latency 2, then chain MUL x3, DIV by zero, chain again.
    set_cmd(0, 4'b0000, 3'd3, 3'd4, 1'b0);
    run_round(4'b0001, 2);
    set_cmd(0, 4'b0010, 3'd0, 3'd3, 1'b1);
    run_round(4'b0001, 2);
    set_cmd(1, 4'b0011, 3'd5, 3'd0, 1'b0);
    run_round(4'b0010, 1);
    set_cmd(0, 4'b0000, 3'd0, 3'd0, 1'b1);
    run_round(4'b0001, 1);
    set_cmd(1, 4'b1000, 3'd2, 3'd2, 1'b1);
    run_round(4'b0010, 1);

    // Reset while waiting, with eng_done in and after the reset cycle.
    set_cmd(0, 4'b0000, 3'd1, 3'd1, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset      = 1'b1;
    eng_done   = 1'b1;
    eng_result = 7'h55;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstw_rsp", {rsp_valid, rsp_result, rsp_err}, 0);
    check("rstw_eng", {eng_start, eng_op, eng_a, eng_b}, 0);
    @(negedge clk);
    eng_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rstw_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;

    // All requesters valid: rotation 0,1,2,3,0; chain exposes cleared memory.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) set_cmd(i, 4'b0000, 3'($urandom), 3'($urandom), 1'b1);
      run_round(4'hF, 1 + r % 3);
    end

    repeat (80) begin
      rand_cmds();
      do v = N'($urandom); while (v == '0);
      run_round(v, $urandom_range(1, 4));
    end

`ifdef CALC_ARB_TIMEOUT_EN
    set_cmd(2, 4'b0000, 3'd1, 3'd2, 1'b0);
    v = 4'b0100;
    req_valid = v;
    #1;
    c = pick(v, m_ptr);
    check("tmo_grant", req_ready, 1 << c);
    m_ptr = (c + 1) % N;
    @(negedge clk);
    req_valid = '0;
    #1;
    check("tmo_start", eng_start, 1);
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while (rsp_valid == '0 && c < 40);
    check("tmo_latency", c - 1, TMO);
    check("tmo_rsp_valid", rsp_valid, 4'b0100);
    check("tmo_result", rsp_result, 0);
    check("tmo_err", rsp_err, 1);
    @(negedge clk);
    eng_done   = 1'b1;
    eng_result = 7'h3C;
    #1;
    check("tmo_late_done", rsp_valid, 0);
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("tmo_late_quiet", rsp_valid, 0);
    set_cmd(2, 4'b0000, 3'd0, 3'd0, 1'b1);
    run_round(4'b0100, 1);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Shares one multi-cycle calculator engine among `N_REQ` independent requesters. Each requester has a valid/ready command port and a result pulse port. A round-robin arbiter grants the engine to one requester at a time and sequences that engine's start/done handshake. A per-requester memory register lets a requester chain operations on its previous result. The block sits between the front-panel/command decoders and the shared calculator datapath.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 64: watchdog limit in cycles; only used when `CALC_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  command valid, one bit per requester.
- `req_ready`  out  N_REQ  command accepted this cycle (one-hot or zero).
- `req_op`  in  N_REQ×4  {ms, op[2:0]} per requester.
- `req_a`  in  N_REQ×3  operand A.
- `req_b`  in  N_REQ×3  operand B.
- `req_chain`  in  N_REQ  use the stored memory value instead of A.
- `rsp_valid`  out  N_REQ  one-cycle result pulse to the owning requester.
- `rsp_result`  out  7  result, shared bus, qualified by `rsp_valid`.
- `rsp_err`  out  1  error flag, qualified by `rsp_valid`.
- `eng_start`  out  1  one-cycle engine start pulse.
- `eng_op`  out  4  op code to the engine.
- `eng_a`  out  7  first operand (zero-extended A, or memory value).
- `eng_b`  out  3  second operand.
- `eng_done`  in  1  engine completion pulse.
- `eng_result`  in  7  engine result, valid with `eng_done`.

## Operation
- Op codes:
  - ms=0: ADD 000, SUB 001, MUL 010, DIV 011.
  - ms=1: SQR 100, CUBE 101, FACT 110, PASS_ADD 111.
  - {0,1xx} and {1,0xx} are illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is set, the round-robin pick `g` gets `req_ready[g]`=1 for that cycle.
  - The block captures op, A, B and chain for `g`.
  - Next state is RESP if the command is illegal or a divide-by-zero; otherwise ISSUE.
- ISSUE:
  - `eng_start`=1 for this cycle, with `eng_*` driven from the captured command.
  - `eng_*` stays stable until `eng_done`.
  - Next state is WAIT.
- WAIT: hold until `eng_done`, then capture `eng_result` and go to RESP.
- RESP:
  - `rsp_valid[g]`=1 for one cycle.
  - On success, write `mem[g]` ← result.
  - Next state is IDLE.
  - The round-robin pointer moves to g+1, wrapping modulo `N_REQ`.
- Error responses:
  - An illegal op returns result 0, err=1.
  - DIV with B==0 returns result 7'h7F, err=1.
  - Neither issues the engine and neither updates `mem`.
- Operand A selection: chain=1 selects `mem[g]`; chain=0 selects {4'b0, A}.
- `mem[g]` resets to 0. Chaining before any completed op therefore uses 0.
- Round-robin: the search starts at the pointer. Requesters that are not valid are skipped. There is no starvation: every valid requester is served within `N_REQ` grants.
- `eng_done` arriving outside WAIT is ignored.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_err`=0.
  - `eng_start`=0, `eng_op`=0, `eng_a`=0, `eng_b`=0.
  - FSM=IDLE, pointer=0, all `mem` cleared.
- Normal latency: accept at cycle t; `eng_start` at t+1; `eng_done` at t+1+k; `rsp_valid` at t+2+k.
- Error latency: accept at t; `rsp_valid` at t+1.
- Throughput: at most one accept per (k+3) cycles. There is no accept during ISSUE, WAIT or RESP.
- A `req_valid` that drops before it is granted is legal; nothing is captured for it.
- Reset mid-operation:
  - Abandons any in-flight op and drops its response.
  - Outputs return to their reset values the next cycle.
  - The engine is assumed to tolerate an abandoned op.
- A same-cycle `eng_done` and `reset`: reset wins.

## Configuration
- `CALC_ARB_TIMEOUT_EN` defined:
  - A WAIT cycle counter runs in WAIT.
  - When the count reaches `TIMEOUT` without `eng_done`, the FSM goes to RESP with result 0 and err=1, and `mem` is not updated.
  - A late `eng_done` is ignored.
- `CALC_ARB_TIMEOUT_EN` not defined: WAIT blocks indefinitely, and the counter logic is absent.

## Structure
- Package `calc_pkg`:
  - op-code localparams (ADD…PASS_ADD).
  - the ms/op field typedef.
  - state enum `calc_arb_state_t`.
  - error constants `CALC_DIV0_RESULT`=7'h7F and `CALC_ILLEGAL_RESULT`=0.
- Sub-module `rr_arbiter`:
  - parameterised by `N_REQ`.
  - inputs: req vector and an advance strobe.
  - output: one-hot grant.
  - it owns the pointer.

## Test plan
- Single requester 0: ADD A=3 B=4 with an engine latency of 2 → `eng_start` at t+1, `rsp_valid[0]` at t+4, result 7, err 0, `mem[0]`=7.
- Chain: requester 0 sends MUL chain=1 B=3 with `mem[0]`=7 → `eng_a`=7, result 21.
- All four requesters valid continuously → grants in order 0,1,2,3,0, with each `rsp_valid` routed to its owner.
- DIV A=5 B=0 → `rsp_valid` at t+1, result 7'h7F, err=1, `eng_start` never asserted, `mem` unchanged.
- Reset asserted in WAIT, then `eng_done` pulses → no `rsp_valid`, FSM in IDLE, `mem` cleared.
- With `CALC_ARB_TIMEOUT_EN` and `TIMEOUT`=8, the engine never responds → `rsp_valid` 8 cycles into WAIT, err=1, result 0; a later `eng_done` is ignored.
